// File: rtl/arima_result_tx.sv
// arima_result_tx
// Output-side collector/transmitter for the ARIMA accelerator.
// Delays in_valid by LATENCY cycles so that it lines up with dp_data.
// Converts each captured Q(DATA_W-FRAC_W).FRAC_W result to a signed
// OUT_W-bit word with OUT_FRAC fractional bits, queues the word in a
// DEPTH-entry FIFO and streams it out over a valid/ready interface.
//
// Optional macro ARIMA_TX_SAT_EN: when defined, converted values clamp
// to the OUT_W signed range and the sticky sat_hit port is present.
// When it is not defined, the low OUT_W bits are kept (wrap).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   start      one-cycle pulse; begins a run (IDLE or DONE only)
//   n_samples  results expected in the run, sampled on start
//   in_valid   a sample entered data_path this cycle
//   dp_data    data_path result, signed, FRAC_W fractional bits
//   m_valid    FIFO head valid
//   m_ready    downstream accepts the head
//   m_data     converted head word
//   m_last     head is the n_samples-th result of the run
//   overflow   sticky: a result was dropped on a full FIFO
//   done       run complete, all results sent
//   count      results captured in the current run (saturating)
//   sat_hit    (ARIMA_TX_SAT_EN only) sticky: a result was clamped
module arima_result_tx #(
   parameter int DATA_W   = 32,
   parameter int FRAC_W   = 15,
   parameter int OUT_W    = 16,
   parameter int OUT_FRAC = 8,
   parameter int LATENCY  = 3,
   parameter int DEPTH    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [31:0]       n_samples,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] dp_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [OUT_W-1:0]  m_data,
   output logic              m_last,
   output logic              overflow,
   output logic              done,
   output logic [31:0]       count
`ifdef ARIMA_TX_SAT_EN
  ,output logic              sat_hit
`endif
);

   localparam int SHIFT = FRAC_W - OUT_FRAC;
   localparam int AW    = $clog2(DEPTH);
   localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t state, state_nxt;

   logic [LATENCY-1:0] dl;
   logic               cap;
   logic               capture;
   logic               start_ok;
   logic [31:0]        n_reg;
   logic [32:0]        cnt_inc;
   logic               cnt_hit;

   logic [OUT_W:0]     mem [0:DEPTH-1];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [AW:0]        occ;
   logic               empty, full, push, pop, drop;

   logic signed [DATA_W-1:0] shifted;
   logic [OUT_W-1:0]         word;

   assign start_ok = start && (state == IDLE || state == DONE);
   assign cap      = dl[LATENCY-1];
   assign capture  = cap && (state == RUN);
   assign cnt_inc  = {1'b0, count} + 33'd1;
   assign cnt_hit  = (cnt_inc == {1'b0, n_reg});

   // Arithmetic right shift floors toward minus infinity.
   assign shifted = $signed(dp_data) >>> SHIFT;

`ifdef ARIMA_TX_SAT_EN
   localparam logic signed [DATA_W-1:0] MAX_V = DATA_W'((2**(OUT_W-1)) - 1);
   localparam logic signed [DATA_W-1:0] MIN_V = ~MAX_V;
   logic clamp;

   always_comb begin
      clamp = 1'b0;
      word  = shifted[OUT_W-1:0];
      if (shifted > MAX_V) begin
         clamp = 1'b1;
         word  = MAX_V[OUT_W-1:0];
      end else if (shifted < MIN_V) begin
         clamp = 1'b1;
         word  = MIN_V[OUT_W-1:0];
      end
   end
`else
   logic unused_high;
   assign unused_high = ^shifted[DATA_W-1:OUT_W];
   assign word = shifted[OUT_W-1:0];
`endif

   assign empty = (occ == '0);
   assign full  = (occ == FULL_OCC);
   assign pop   = m_valid && m_ready;
   // A pop on the same edge frees a slot, so a full FIFO still accepts.
   assign push  = capture && (!full || pop);
   assign drop  = capture && full && !pop;

   assign m_valid = !empty;
   assign m_data  = m_valid ? mem[rd_ptr][OUT_W-1:0] : '0;
   assign m_last  = m_valid && mem[rd_ptr][OUT_W];

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      done      = (state == DONE);
      case (state)
         IDLE, DONE: begin
            if (start) state_nxt = (n_samples == '0) ? DONE : RUN;
         end
         RUN: begin
            if (capture && cnt_hit) state_nxt = DRAIN;
         end
         DRAIN: begin
            // No pushes here, so popping the only entry empties the FIFO.
            if (empty || (pop && occ == (AW+1)'(1))) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cnt_hit, word};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         dl       <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         occ      <= '0;
         count    <= '0;
         overflow <= 1'b0;
         n_reg    <= '0;
`ifdef ARIMA_TX_SAT_EN
         sat_hit  <= 1'b0;
`endif
      end else if (start_ok) begin
         dl       <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         occ      <= '0;
         count    <= '0;
         overflow <= 1'b0;
         n_reg    <= n_samples;
`ifdef ARIMA_TX_SAT_EN
         sat_hit  <= 1'b0;
`endif
      end else begin
         dl[0] <= in_valid && (state == RUN);
         for (int unsigned i = 1; i < LATENCY; i++) dl[i] <= dl[i-1];

         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase

         if (capture && count != '1) count <= count + 1'b1;
         if (drop) overflow <= 1'b1;
`ifdef ARIMA_TX_SAT_EN
         if (capture && clamp) sat_hit <= 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_arima_result_tx.sv
module tb_arima_result_tx;
   localparam int DATA_W   = 32;
   localparam int FRAC_W   = 15;
   localparam int OUT_W    = 16;
   localparam int OUT_FRAC = 8;
   localparam int LAT      = 3;
   localparam int DEPTH    = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, start, in_valid, m_ready;
   logic              m_valid, m_last, overflow, done;
   logic [31:0]       n_samples, count;
   logic [DATA_W-1:0] dp_data, iv_data;
   logic [OUT_W-1:0]  m_data;
`ifdef ARIMA_TX_SAT_EN
   logic              sat_hit;
`endif

   int checks = 0;
   int passed = 0;

   typedef struct packed {
      logic [OUT_W-1:0] d;
      logic             l;
   } exp_t;
   exp_t sb[$];

   arima_result_tx #(
      .DATA_W(DATA_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W),
      .OUT_FRAC(OUT_FRAC), .LATENCY(LAT), .DEPTH(DEPTH)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
      .in_valid(in_valid), .dp_data(dp_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .overflow(overflow), .done(done), .count(count)
`ifdef ARIMA_TX_SAT_EN
     ,.sat_hit(sat_hit)
`endif
   );

   // data_path stand-in: the value tagged to an in_valid appears on
   // dp_data LAT cycles later; every other cycle carries random junk.
   logic              hv [LAT];
   logic [DATA_W-1:0] hd [LAT];
   always @(posedge clk) begin
      for (int i = LAT-1; i > 0; i--) begin
         hv[i] = hv[i-1];
         hd[i] = hd[i-1];
      end
      hv[0] = in_valid;
      hd[0] = iv_data;
      #1;
      dp_data = (hv[LAT-1] === 1'b1) ? hd[LAT-1] : $urandom();
   end

   // Reference conversion: floor(value / 2^(FRAC_W-OUT_FRAC)), then wrap
   // (or clamp) to the OUT_W signed range.
   function automatic logic [OUT_W-1:0] conv(input logic [DATA_W-1:0] d);
      longint v, dv, q, mx, mn;
      logic [63:0] qq;
      v  = longint'($signed(d));
      dv = longint'(1) << (FRAC_W - OUT_FRAC);
      if (v >= 0) q = v / dv;
      else        q = -((-v + dv - 1) / dv);
      mx = (longint'(1) << (OUT_W-1)) - 1;
      mn = -(longint'(1) << (OUT_W-1));
`ifdef ARIMA_TX_SAT_EN
      if (q > mx) q = mx;
      if (q < mn) q = mn;
`else
      if (mx < mn) q = 0;
`endif
      qq = q;
      return qq[OUT_W-1:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [DATA_W-1:0] d, input bit expect_it, input bit last);
      in_valid = 1'b1;
      iv_data  = d;
      if (expect_it) sb.push_back('{conv(d), last});
      step();
      in_valid = 1'b0;
   endtask

   task automatic start_run(input logic [31:0] n);
      n_samples = n;
      start     = 1'b1;
      step();
      start     = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit rand_ready);
      for (int c = 0; c < budget; c++) begin
         if (done === 1'b1) break;
         if (rand_ready) m_ready = 1'($urandom_range(0, 1));
         step();
      end
      chk("done_reached", done, 1);
   endtask

   // Scoreboard monitor: a handshake visible at the negedge is a pop.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (m_valid === 1'b1 && m_ready === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               $display("FAIL unexpected_word: got %0h with nothing expected (t=%0t)", m_data, $time);
            end else begin
               e = sb.pop_front();
               chk("m_data", m_data, e.d);
               chk("m_last", m_last, e.l);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n, issued;
      rst = 1'b0; start = 1'b0; in_valid = 1'b0; m_ready = 1'b0;
      n_samples = '0; iv_data = '0; dp_data = '0;
      repeat (3) step();
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_done", done, 0);
      chk("rst_count", count, 0);
      chk("rst_overflow", overflow, 0);
      rst = 1'b1;
      step();

      // in_valid is ignored while idle
      repeat (3) issue($urandom(), 0, 0);
      repeat (LAT+2) step();
      chk("idle_m_valid", m_valid, 0);
      chk("idle_count", count, 0);

      // n_samples == 0 goes straight to DONE
      start_run(0);
      chk("n0_done", done, 1);
      chk("n0_m_valid", m_valid, 0);

      // basic run
      m_ready = 1'b1;
      start_run(3);
      chk("run_done_clear", done, 0);
      issue(32'h0000_8000, 1, 0);
      issue(32'hFFFF_0000, 1, 0);
      issue(32'h0000_4000, 1, 1);
      wait_done(50, 0);
      chk("basic_count", count, 3);
      chk("basic_sb_empty", sb.size(), 0);
`ifdef ARIMA_TX_SAT_EN
      chk("basic_sat_hit", sat_hit, 0);
`endif

      // latency: m_valid appears exactly LAT cycles after in_valid
      m_ready = 1'b0;
      start_run(1);
      in_valid = 1'b1;
      iv_data  = $urandom();
      sb.push_back('{conv(iv_data), 1'b1});
      step();
      in_valid = 1'b0;
      for (int t = 0; t <= LAT; t++) begin
         @(negedge clk);
         chk("lat_m_valid", m_valid, (t == LAT) ? 1 : 0);
      end
      step();
      m_ready = 1'b1;
      wait_done(50, 0);
      chk("lat_sb_empty", sb.size(), 0);

      // backpressure and overflow
      m_ready = 1'b0;
      start_run(20);
      for (int i = 0; i < 20; i++) issue($urandom(), i < DEPTH, i == 19);
      repeat (LAT+1) step();
      chk("ovf_overflow", overflow, 1);
      chk("ovf_count", count, 20);
      chk("ovf_m_valid", m_valid, 1);
      chk("ovf_done", done, 0);
      m_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         chk("drain_no_gap", m_valid, 1);
      end
      @(negedge clk);
      chk("drain_done", done, 1);
      chk("drain_empty", m_valid, 0);
      chk("drain_sb_empty", sb.size(), 0);
      step();

      // full FIFO with a pop on the capture edge: nothing is dropped
      m_ready = 1'b0;
      start_run(24);
      for (int i = 0; i < 24; i++) begin
         if (i == DEPTH + LAT) m_ready = 1'b1;
         issue($urandom(), 1, i == 23);
      end
      wait_done(200, 0);
      chk("fullpop_overflow", overflow, 0);
      chk("fullpop_count", count, 24);
      chk("fullpop_sb_empty", sb.size(), 0);

      // range extremes
      m_ready = 1'b1;
      start_run(2);
      issue(32'h7FFF_FFFF, 1, 0);
      issue(32'h8000_0000, 1, 1);
      wait_done(50, 0);
      chk("range_sb_empty", sb.size(), 0);
`ifdef ARIMA_TX_SAT_EN
      chk("range_sat_hit", sat_hit, 1);
`endif

      // randomized runs; a stray start mid-run must be ignored
      for (int r = 0; r < 5; r++) begin
         n = $urandom_range(1, 25);
         start_run(n);
         issued = 0;
         for (int cyc = 0; cyc < 2000 && issued < n; cyc++) begin
            in_valid = 1'b0;
            m_ready  = 1'($urandom_range(0, 1));
            if (cyc == 5) begin
               start     = 1'b1;
               n_samples = n + 7;
            end else begin
               start = 1'b0;
            end
            if ($urandom_range(0, 1) == 1 && sb.size() < DEPTH-2) begin
               in_valid = 1'b1;
               iv_data  = $urandom();
               sb.push_back('{conv(iv_data), (issued + 1 == n)});
               issued++;
            end
            step();
         end
         start    = 1'b0;
         in_valid = 1'b0;
         wait_done(500, 1);
         chk("rand_count", count, n);
         chk("rand_overflow", overflow, 0);
         chk("rand_sb_empty", sb.size(), 0);
      end

      // reset while draining discards the queued words
      m_ready = 1'b0;
      start_run(5);
      for (int i = 0; i < 5; i++) issue($urandom(), 0, 0);
      repeat (LAT+1) step();
      chk("drainrst_count_before", count, 5);
      chk("drainrst_m_valid_before", m_valid, 1);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("drainrst_m_valid", m_valid, 0);
      chk("drainrst_count", count, 0);
      chk("drainrst_m_data", m_data, 0);
      chk("drainrst_done", done, 0);
      m_ready = 1'b1;
      start_run(1);
      issue(32'h0001_2345, 1, 1);
      wait_done(50, 0);
      chk("postrst_count", count, 1);
      chk("postrst_sb_empty", sb.size(), 0);

      step();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
